cache_arbiter_n: RTL and testbench



---
 rtl/cache_arbiter_pkg.sv | 13 +
 rtl/arb_rr_pick.sv | 34 +++
 rtl/cache_arbiter_n.sv | 140 ++++++++++++++
 tb/tb_cache_arbiter_n.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared types and limits for the N-requester memory arbiter.
package cache_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_BUFFER
    } arb_state_t;

    // Largest supported requester count; the grant index never exceeds 3 bits.
    localparam int MAX_N_REQ = 8;

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational wrap-around picker. Starting at i_start, returns
// the first requester with its bit set, searching upward and wrapping to 0.
// With i_start tied to 0 this is plain fixed priority, lowest index wins.
module arb_rr_pick #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Choose the requester with the smallest wrapped distance from the start.
    always_comb begin
        int v_start;
        int v_dist;
        int v_best;
        o_valid = 1'b0;
        o_idx   = '0;
        v_start = int'(i_start);
        v_dist  = 0;
        v_best  = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            v_dist = (i >= v_start) ? (i - v_start) : (i + N_REQ - v_start);
            if (i_req[i] && (v_dist < v_best)) begin
                v_best  = v_dist;
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_arbiter_n.sv
// cache_arbiter_n: N-requester arbiter in front of the single L2/memory port.
// Full address/data mux, one-hot response routing, one-cycle turnaround slot.
// Optional feature macro: CACHE_ARBITER_RR_EN (round-robin pointer). When it is
// undefined the search always starts at index 0 (fixed priority).
//
// state      | meaning
// -----------+----------------------------------------------------------
// ARB_IDLE   | no grant; picker chooses a winner for the next cycle
// ARB_GRANT  | requester r_grant owns the downstream port
// ARB_BUFFER | turnaround after completion; downstream request forced off
module cache_arbiter_n
    import cache_arbiter_pkg::*;
#(
    parameter  int N_REQ  = 2,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 256,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_read,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_resp,
    output logic [DATA_W-1:0]       req_rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_resp,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    busy
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] w_start;
    logic [N_REQ-1:0] w_req_any;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;

    assign w_req_any = req_read | req_write;

    arb_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req   (w_req_any),
        .i_start (w_start),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

`ifdef CACHE_ARBITER_RR_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_inc;

    assign w_ptr_inc = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : (r_grant + IDX_W'(1));
    assign w_start   = r_ptr;

    // Pointer moves just past the owner only when its request completes; aborts leave it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if ((r_state == ARB_GRANT) && mem_resp) begin
            r_ptr <= w_ptr_inc;
        end
    end
`else
    assign w_start = '0;
`endif

    // State and owner registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Next state: a response always wins over a simultaneous request drop.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            ARB_IDLE, ARB_BUFFER: begin
                if (w_pick_valid) begin
                    w_state_nxt = ARB_GRANT;
                    w_grant_nxt = w_pick_idx;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (mem_resp) begin
                    w_state_nxt = ARB_BUFFER;
                end else if (!w_req_any[r_grant]) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Downstream mux and response routing; everything is zero outside GRANT.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        req_resp  = '0;
        grant_idx = '0;
        busy      = 1'b0;
        if (r_state == ARB_GRANT) begin
            busy      = 1'b1;
            grant_idx = r_grant;
            for (int i = 0; i < N_REQ; i++) begin
                if (r_grant == IDX_W'(i)) begin
                    mem_read    = req_read[i];
                    mem_write   = req_write[i];
                    mem_addr    = req_addr[i*ADDR_W +: ADDR_W];
                    mem_wdata   = req_wdata[i*DATA_W +: DATA_W];
                    req_resp[i] = mem_resp;
                end
            end
        end
    end

    assign req_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter_n.sv
// tb_cache_arbiter_n: directed bench for cache_arbiter_n with N_REQ=4.
// Follows CACHE_ARBITER_RR_EN the same way the design does.
`timescale 1ns/1ps
module tb_cache_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 256;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_read;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_resp;
    logic [DW-1:0]     req_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_resp;
    logic [DW-1:0]     mem_rdata;
    logic [1:0]        grant_idx;
    logic              busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int exp_q[$];

    int m_owner = -1;
    int m_ptr   = 0;

    cache_arbiter_n #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_read  (req_read),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_resp  (req_resp),
        .req_rdata (req_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Wrap-around search from start: first requesting index, or -1.
    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int o = 0; o < N; o++) begin
            int i;
            i = (start + o) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: who owns the port and where the next search starts.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
        end else if (m_owner >= 0) begin
            if (mem_resp) begin
`ifdef CACHE_ARBITER_RR_EN
                m_ptr <= (m_owner + 1) % N;
`endif
                m_owner <= -1;
            end else if (!(req_read[m_owner] | req_write[m_owner])) begin
                m_owner <= -1;
            end
        end else begin
            m_owner <= pick(req_read | req_write, m_ptr);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_wdata;
            logic [N-1:0]  e_resp;
            logic          e_rd;
            logic          e_wr;
            e_addr  = '0;
            e_wdata = '0;
            e_resp  = '0;
            e_rd    = 1'b0;
            e_wr    = 1'b0;
            if (m_owner >= 0) begin
                e_addr  = req_addr[m_owner*AW +: AW];
                e_wdata = req_wdata[m_owner*DW +: DW];
                e_rd    = req_read[m_owner];
                e_wr    = req_write[m_owner];
                if (mem_resp) e_resp[m_owner] = 1'b1;
            end
            chk("cyc_busy", busy, (m_owner >= 0));
            chk("cyc_grant_idx", grant_idx, (m_owner >= 0) ? m_owner : 0);
            chk("cyc_mem_read", mem_read, e_rd);
            chk("cyc_mem_write", mem_write, e_wr);
            chk("cyc_mem_addr", mem_addr, e_addr);
            chk("cyc_mem_wdata", mem_wdata, e_wdata);
            chk("cyc_req_resp", req_resp, e_resp);
            if (e_resp != 0) chk("cyc_req_rdata", req_rdata, mem_rdata);
            if (mem_read && mem_write) begin
                errors++;
                $display("FAIL illegal_rw actual=mem_read&mem_write required=exclusive t=%0t", $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int bound);
        int n;
        n = 0;
        while (!busy && n < bound) begin
            tick();
            n++;
        end
        chk("grant_wait", busy, 1'b1);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_read  = '0;
        req_write = '0;
        mem_resp  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Hold the given read requests, complete n grants, check order and dead cycle.
    task automatic run_seq(input logic [N-1:0] reqs, input int n, input int hold);
        do_reset();
        req_read = reqs;
        for (int k = 0; k < n; k++) begin
            wait_grant(8);
            chk("seq_grant", grant_idx, exp_q[k]);
            repeat (hold - 1) tick();
            mem_resp = 1'b1;
            #1;
            chk("seq_resp", req_resp, 4'(1 << exp_q[k]));
            tick();
            mem_resp = 1'b0;
            #1;
            chk("seq_dead_rw", {mem_read, mem_write}, 2'b00);
            chk("seq_dead_busy", busy, 1'b0);
        end
        req_read = '0;
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        req_read  = '0;
        req_write = '0;
        mem_resp  = 1'b0;
        mem_rdata = {8{32'hDEAD_BEEF}};
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = 32'h1000_0000 + 32'(i) * 32'h100;
            req_wdata[i*DW +: DW] = {8{32'hC0DE_0000 + 32'(i)}};
        end
        tick();
        chk_en = 1'b1;

        // Reset state and basic two-requester handoff.
        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_idx", grant_idx, 2'd0);
        chk("rst_mem_read", mem_read, 1'b0);
        req_read = 4'b0011;
        tick();
        chk("s1_mem_read", mem_read, 1'b1);
        chk("s1_grant_idx", grant_idx, 2'd0);
        chk("s1_mem_addr", mem_addr, 32'h1000_0000);
        tick();
        tick();
        mem_resp = 1'b1;
        #1;
        chk("s1_resp", req_resp, 4'b0001);
        chk("s1_rdata", req_rdata, {8{32'hDEAD_BEEF}});
        tick();
        mem_resp    = 1'b0;
        req_read[0] = 1'b0;
        #1;
        chk("s1_buffer_read", mem_read, 1'b0);
        chk("s1_buffer_busy", busy, 1'b0);
        tick();
        chk("s1_second_grant", grant_idx, 2'd1);
        chk("s1_second_addr", mem_addr, 32'h1000_0100);
        mem_resp = 1'b1;
        #1;
        chk("s1_second_resp", req_resp, 4'b0010);
        tick();
        mem_resp = 1'b0;
        req_read = '0;
        tick();

        // All four held continuously.
        exp_q.delete();
`ifdef CACHE_ARBITER_RR_EN
        exp_q = '{0, 1, 2, 3, 0};
`else
        exp_q = '{0, 0, 0, 0, 0};
`endif
        run_seq(4'b1111, 5, 2);

        // Requesters 2 and 3 held, response three cycles into each grant.
        exp_q.delete();
`ifdef CACHE_ARBITER_RR_EN
        exp_q = '{2, 3, 2};
`else
        exp_q = '{2, 2, 2};
`endif
        run_seq(4'b1100, 3, 3);

        // Abort leaves the pointer alone; stray response is ignored.
        do_reset();
        req_read = 4'b0001;
        tick();
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        req_read = 4'b0100;
        tick();
        chk("ab_grant", grant_idx, 2'd2);
        tick();
        tick();
        req_read = '0;
        tick();
        chk("ab_idle_busy", busy, 1'b0);
        chk("ab_idle_idx", grant_idx, 2'd0);
        mem_resp = 1'b1;
        #1;
        chk("ab_stray_resp", req_resp, 4'b0000);
        tick();
        mem_resp = 1'b0;
        #1;
        chk("ab_stray_busy", busy, 1'b0);
        req_read = 4'b0011;
        tick();
`ifdef CACHE_ARBITER_RR_EN
        chk("ab_ptr_kept", grant_idx, 2'd1);
`else
        chk("ab_ptr_kept", grant_idx, 2'd0);
`endif
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        req_read = '0;
        tick();

        // Write path through requester 1.
        do_reset();
        req_addr[1*AW +: AW]  = 32'h0000_1040;
        req_wdata[1*DW +: DW] = {32{8'hA5}};
        req_write = 4'b0010;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("wr_mem_write", mem_write, 1'b1);
            chk("wr_mem_read", mem_read, 1'b0);
            chk("wr_mem_addr", mem_addr, 32'h0000_1040);
            chk("wr_mem_wdata", mem_wdata, {32{8'hA5}});
            if (i < 2) tick();
        end
        mem_resp = 1'b1;
        #1;
        chk("wr_resp", req_resp, 4'b0010);
        tick();
        mem_resp  = 1'b0;
        req_write = '0;
        tick();

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req_read = 4'b0100;
        tick();
        chk("rg_busy_before", busy, 1'b1);
        chk("rg_read_before", mem_read, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rg_read_async", mem_read, 1'b0);
        chk("rg_busy_async", busy, 1'b0);
        chk("rg_idx_async", grant_idx, 2'd0);
        tick();
        tick();
        req_read = 4'b1001;
        reset_n  = 1'b1;
        tick();
        chk("rg_first_grant", grant_idx, 2'd0);
        chk("rg_first_busy", busy, 1'b1);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        req_read = '0;
        tick();
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
